nrzi_bit_stuffer: RTL and testbench

- Upstream stage of the nrzi line encoder.
- Accepts bytes over a valid/ready handshake and serialises them LSB-first.
- Inserts a 0 after every STUFF_LEN consecutive 1s, USB-style, so the encoder's output keeps transitions.
- Produces one bit per clock on bit_o/bit_valid_o, which drive the encoder's serial data input directly.

---
 rtl/nrzi_pkg.sv | 17 +
 rtl/nrzi_byte_hold.sv | 40 ++++
 rtl/nrzi_bit_stuffer.sv | 145 ++++++++++++++
 tb/tb_nrzi_bit_stuffer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nrzi_pkg.sv
// Shared types and sizing helpers for the NRZI transmit/receive bit stuffing path.
package nrzi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    STUFF
  } state_e;

  localparam int STUFF_LEN_DEFAULT = 6;

  // Width of a counter that must hold 0..stuff_len inclusive.
  function automatic int ones_cnt_w(input int stuff_len);
    return $clog2(stuff_len + 1);
  endfunction

endpackage

// File: rtl/nrzi_byte_hold.sv
// Single-entry holding register with a valid/ready front and a pop from the consumer.
// ready_o is the registered empty flag, so the producer never sees a combinational path.
module nrzi_byte_hold
  import nrzi_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk_i,
  input  logic         resetn_i,
  input  logic [W-1:0] data_i,
  input  logic         valid_i,
  output logic         ready_o,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  input  logic         pop_i
);

  logic         empty_q;
  logic [W-1:0] data_q;
  logic         push;

  assign push    = valid_i && empty_q;
  assign ready_o = empty_q;
  assign valid_o = !empty_q;
  assign data_o  = data_q;

  // Capture on push; a pop and a push on the same edge leave the entry full.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      empty_q <= 1'b1;
      data_q  <= '0;
    end else begin
      if (push) begin
        data_q <= data_i;
      end
      empty_q <= !(push || (!empty_q && !pop_i));
    end
  end

endmodule

// File: rtl/nrzi_bit_stuffer.sv
// Byte-to-bit serialiser with USB-style zero stuffing, feeding the NRZI encoder.
//
// state | meaning
// IDLE  | no bit on the line; waits for the holding register to fill
// SHIFT | presenting data bit idx_q of the current byte
// STUFF | presenting an inserted 0 after STUFF_LEN consecutive data 1s
module nrzi_bit_stuffer
  import nrzi_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int STUFF_LEN = STUFF_LEN_DEFAULT
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic [DATA_W-1:0] byte_i,
  input  logic              byte_valid_i,
  input  logic              last_i,
  output logic              byte_ready_o,
  output logic              bit_o,
  output logic              bit_valid_o,
  output logic              stuff_o,
  output logic              underrun_o
);

  localparam int ONES_W = ones_cnt_w(STUFF_LEN);
  localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [ONES_W-1:0] ONES_MAX = ONES_W'(STUFF_LEN);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_W - 1);

  logic [DATA_W:0] hold_data;
  logic            hold_full;
  logic            hold_pop;

  nrzi_byte_hold #(
    .W(DATA_W + 1)
  ) u_hold (
    .clk_i   (clk_i),
    .resetn_i(resetn_i),
    .data_i  ({last_i, byte_i}),
    .valid_i (byte_valid_i),
    .ready_o (byte_ready_o),
    .data_o  (hold_data),
    .valid_o (hold_full),
    .pop_i   (hold_pop)
  );

  state_e            state_q;
  logic [DATA_W-1:0] shreg_q;
  logic              last_q;
  logic [IDX_W-1:0]  idx_q;
  logic [ONES_W-1:0] ones_q;
  logic              bit_q;
  logic              valid_q;
  logic              stuff_q;
  logic              underrun_q;

  logic              at_end;
  logic              run_full;
  logic              byte_done;
  logic              nxt_bit;
  logic [IDX_W-1:0]  nxt_idx;
  logic [ONES_W-1:0] cont_ones;
  logic [ONES_W-1:0] load_base;
  logic [ONES_W-1:0] load_ones;

  // Next-bit lookahead and the decision to pull the next byte out of the holding register.
  always_comb begin
    at_end    = (idx_q == IDX_LAST);
    run_full  = (ones_q == ONES_MAX);
    nxt_idx   = idx_q + 1'b1;
    nxt_bit   = at_end ? 1'b0 : shreg_q[nxt_idx];
    cont_ones = nxt_bit ? ones_q + 1'b1 : '0;
    byte_done = ((state_q == SHIFT) && !run_full && at_end) ||
                ((state_q == STUFF) && at_end);
    hold_pop  = hold_full && ((state_q == IDLE) || byte_done);
    // The run of 1s carries into the next byte only inside a packet.
    load_base = last_q ? '0 : ones_q;
    load_ones = hold_data[0] ? load_base + 1'b1 : '0;
  end

  // Main sequencer; every output is registered and describes the bit on the line this cycle.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      last_q     <= 1'b0;
      idx_q      <= '0;
      ones_q     <= '0;
      bit_q      <= 1'b0;
      valid_q    <= 1'b0;
      stuff_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= 1'b0;
      stuff_q    <= 1'b0;
      if (hold_pop) begin
        shreg_q <= hold_data[DATA_W-1:0];
        last_q  <= hold_data[DATA_W];
        idx_q   <= '0;
        ones_q  <= load_ones;
        bit_q   <= hold_data[0];
        valid_q <= 1'b1;
        state_q <= SHIFT;
      end else begin
        unique case (state_q)
          IDLE: begin
            bit_q   <= 1'b0;
            valid_q <= 1'b0;
          end
          SHIFT, STUFF: begin
            if ((state_q == SHIFT) && run_full) begin
              bit_q   <= 1'b0;
              stuff_q <= 1'b1;
              valid_q <= 1'b1;
              ones_q  <= '0;
              state_q <= STUFF;
            end else if (!at_end) begin
              idx_q   <= nxt_idx;
              bit_q   <= nxt_bit;
              ones_q  <= cont_ones;
              valid_q <= 1'b1;
              state_q <= SHIFT;
            end else begin
              // Byte finished with nothing queued: either a clean packet end or a starved stream.
              bit_q      <= 1'b0;
              valid_q    <= 1'b0;
              ones_q     <= '0;
              underrun_q <= !last_q;
              state_q    <= IDLE;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bit_o       = bit_q;
  assign bit_valid_o = valid_q;
  assign stuff_o     = stuff_q;
  assign underrun_o  = underrun_q;

endmodule

// File: tb/tb_nrzi_bit_stuffer.sv
// Self-checking bench for nrzi_bit_stuffer: directed packets plus randomized streams
// compared against a bitstream-level stuffing model.
module tb_nrzi_bit_stuffer;

  localparam int DATA_W    = 8;
  localparam int STUFF_LEN = 6;

  logic              clk_i        = 1'b0;
  logic              resetn_i     = 1'b0;
  logic [DATA_W-1:0] byte_i       = '0;
  logic              byte_valid_i = 1'b0;
  logic              last_i       = 1'b0;
  logic              byte_ready_o;
  logic              bit_o;
  logic              bit_valid_o;
  logic              stuff_o;
  logic              underrun_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_i = ~clk_i;

  nrzi_bit_stuffer #(
    .DATA_W   (DATA_W),
    .STUFF_LEN(STUFF_LEN)
  ) dut (
    .clk_i       (clk_i),
    .resetn_i    (resetn_i),
    .byte_i      (byte_i),
    .byte_valid_i(byte_valid_i),
    .last_i      (last_i),
    .byte_ready_o(byte_ready_o),
    .bit_o       (bit_o),
    .bit_valid_o (bit_valid_o),
    .stuff_o     (stuff_o),
    .underrun_o  (underrun_o)
  );

  logic [7:0]   tx_byte[$];
  bit           tx_last[$];

  logic [127:0] obs_bits, obs_stuff;
  int           nv, first_v, last_v, gaps, n_under, under_pos, n_sent, first_acc;
  logic         end_ready, end_valid;

  logic [127:0] exp_bits, exp_stuff;
  int           exp_len, exp_under;

  // Transmission-order string ("1101...") to a vector whose bit i is the i-th bit on the line.
  function automatic logic [127:0] s2v(input string s);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < s.len(); i++) v[i] = (s[i] == 8'h31);
    return v;
  endfunction

  // Reference: flatten bytes LSB-first, append a 0 after every STUFF_LEN ones, restart count per packet.
  function automatic void model();
    int   ones;
    logic b;
    ones      = 0;
    exp_bits  = '0;
    exp_stuff = '0;
    exp_len   = 0;
    for (int k = 0; k < tx_byte.size(); k++) begin
      for (int i = 0; i < DATA_W; i++) begin
        b = tx_byte[k][i];
        exp_bits[exp_len] = b;
        exp_len++;
        ones = b ? ones + 1 : 0;
        if (ones == STUFF_LEN) begin
          exp_stuff[exp_len] = 1'b1;
          exp_bits[exp_len]  = 1'b0;
          exp_len++;
          ones = 0;
        end
      end
      if (tx_last[k]) ones = 0;
    end
    exp_under = (tx_last.size() > 0 && !tx_last[tx_last.size()-1]) ? 1 : 0;
  endfunction

  // Offers tx_byte in order whenever ready, records every output sample for a fixed number of cycles.
  task automatic run_stream(input int cycles);
    logic acc;
    obs_bits  = '0;
    obs_stuff = '0;
    nv = 0; first_v = -1; last_v = -1; n_under = 0; under_pos = -1; n_sent = 0; first_acc = -1;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk_i);
      if (bit_valid_o) begin
        if (nv < 128) begin
          obs_bits[nv]  = bit_o;
          obs_stuff[nv] = stuff_o;
        end
        nv++;
        if (first_v < 0) first_v = c;
        last_v = c;
      end
      if (underrun_o) begin
        n_under++;
        under_pos = c;
      end
      if (n_sent < tx_byte.size()) begin
        byte_valid_i = 1'b1;
        byte_i       = tx_byte[n_sent];
        last_i       = tx_last[n_sent];
      end else begin
        byte_valid_i = 1'b0;
        last_i       = 1'b0;
      end
      acc = byte_valid_i && byte_ready_o;
      if (acc && first_acc < 0) first_acc = c;
      @(posedge clk_i);
      if (acc) n_sent++;
    end
    @(negedge clk_i);
    byte_valid_i = 1'b0;
    end_ready    = byte_ready_o;
    end_valid    = bit_valid_o;
    gaps = (first_v < 0) ? 0 : (last_v - first_v + 1) - nv;
  endtask

  task automatic test_reset();
    resetn_i = 1'b0;
    repeat (2) @(negedge clk_i);
    n_checks++;
    if ({byte_ready_o, bit_valid_o, bit_o, stuff_o, underrun_o} !== 5'b10000)
      $display("FAIL reset_in: got %b expected 10000", {byte_ready_o, bit_valid_o, bit_o, stuff_o, underrun_o});
    else n_pass++;
    resetn_i = 1'b1;
    repeat (3) @(negedge clk_i);
    n_checks++;
    if ({byte_ready_o, bit_valid_o, bit_o, stuff_o, underrun_o} !== 5'b10000)
      $display("FAIL reset_idle: got %b expected 10000", {byte_ready_o, bit_valid_o, bit_o, stuff_o, underrun_o});
    else n_pass++;
  endtask

  task automatic test_zero();
    tx_byte = '{8'h00};
    tx_last = '{1'b1};
    run_stream(20);
    n_checks++;
    if (nv !== 8 || obs_bits !== s2v("00000000"))
      $display("FAIL zero_bits: got n=%0d %h expected n=8 %h", nv, obs_bits, s2v("00000000"));
    else n_pass++;
    n_checks++;
    if (obs_stuff !== '0) $display("FAIL zero_stuff: got %h expected 0", obs_stuff);
    else n_pass++;
    n_checks++;
    if (gaps !== 0 || first_v !== first_acc + 2)
      $display("FAIL zero_timing: got gaps=%0d first=%0d expected gaps=0 first=%0d", gaps, first_v, first_acc + 2);
    else n_pass++;
    n_checks++;
    if (n_under !== 0 || end_ready !== 1'b1 || end_valid !== 1'b0)
      $display("FAIL zero_end: got under=%0d ready=%b valid=%b expected 0 1 0", n_under, end_ready, end_valid);
    else n_pass++;
  endtask

  task automatic test_all_ones();
    tx_byte = '{8'hFF};
    tx_last = '{1'b1};
    run_stream(20);
    n_checks++;
    if (nv !== 9 || obs_bits !== s2v("111111011"))
      $display("FAIL ones_bits: got n=%0d %h expected n=9 %h", nv, obs_bits, s2v("111111011"));
    else n_pass++;
    n_checks++;
    if (obs_stuff !== s2v("000000100"))
      $display("FAIL ones_stuff: got %h expected %h", obs_stuff, s2v("000000100"));
    else n_pass++;
    n_checks++;
    if (gaps !== 0 || first_v !== first_acc + 2 || n_under !== 0)
      $display("FAIL ones_timing: got gaps=%0d first=%0d under=%0d expected 0 %0d 0", gaps, first_v, n_under, first_acc + 2);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    tx_byte = '{8'hFF, 8'h3F};
    tx_last = '{1'b0, 1'b1};
    run_stream(32);
    n_checks++;
    if (nv !== 18 || obs_bits !== s2v("111111011111101100"))
      $display("FAIL b2b_bits: got n=%0d %h expected n=18 %h", nv, obs_bits, s2v("111111011111101100"));
    else n_pass++;
    n_checks++;
    if (obs_stuff !== s2v("000000100000010000"))
      $display("FAIL b2b_stuff: got %h expected %h", obs_stuff, s2v("000000100000010000"));
    else n_pass++;
    n_checks++;
    if (gaps !== 0 || n_under !== 0 || n_sent !== 2)
      $display("FAIL b2b_flow: got gaps=%0d under=%0d sent=%0d expected 0 0 2", gaps, n_under, n_sent);
    else n_pass++;
  endtask

  task automatic test_trailing_stuff();
    tx_byte = '{8'hFC, 8'h01};
    tx_last = '{1'b1, 1'b1};
    run_stream(32);
    n_checks++;
    if (nv !== 17 || obs_bits !== s2v("00111111010000000"))
      $display("FAIL trail_bits: got n=%0d %h expected n=17 %h", nv, obs_bits, s2v("00111111010000000"));
    else n_pass++;
    n_checks++;
    if (obs_stuff !== s2v("00000000100000000"))
      $display("FAIL trail_stuff: got %h expected %h", obs_stuff, s2v("00000000100000000"));
    else n_pass++;
    n_checks++;
    if (n_under !== 0 || end_ready !== 1'b1 || end_valid !== 1'b0)
      $display("FAIL trail_end: got under=%0d ready=%b valid=%b expected 0 1 0", n_under, end_ready, end_valid);
    else n_pass++;
  endtask

  task automatic test_packet_boundary();
    tx_byte = '{8'hF0, 8'h03};
    tx_last = '{1'b1, 1'b1};
    run_stream(32);
    n_checks++;
    if (nv !== 16 || obs_bits !== s2v("0000111111000000") || obs_stuff !== '0)
      $display("FAIL pkt_boundary: got n=%0d %h stuff=%h expected n=16 %h stuff=0", nv, obs_bits, obs_stuff, s2v("0000111111000000"));
    else n_pass++;
  endtask

  task automatic test_underrun();
    tx_byte = '{8'hAA};
    tx_last = '{1'b0};
    run_stream(20);
    n_checks++;
    if (nv !== 8 || obs_bits !== s2v("01010101"))
      $display("FAIL under_bits: got n=%0d %h expected n=8 %h", nv, obs_bits, s2v("01010101"));
    else n_pass++;
    n_checks++;
    if (n_under !== 1 || under_pos !== last_v + 1)
      $display("FAIL under_pulse: got count=%0d pos=%0d expected count=1 pos=%0d", n_under, under_pos, last_v + 1);
    else n_pass++;
    n_checks++;
    if (end_valid !== 1'b0 || end_ready !== 1'b1)
      $display("FAIL under_end: got valid=%b ready=%b expected 0 1", end_valid, end_ready);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int waited;
    int bad;
    waited = 0;
    bad    = 0;
    @(negedge clk_i);
    byte_valid_i = 1'b1;
    byte_i       = 8'hFF;
    last_i       = 1'b1;
    @(negedge clk_i);
    byte_valid_i = 1'b0;
    while (!bit_valid_o && waited < 10) begin
      @(negedge clk_i);
      waited++;
    end
    n_checks++;
    if (bit_valid_o !== 1'b1) $display("FAIL rstmid_start: got valid=%b expected 1", bit_valid_o);
    else n_pass++;
    repeat (4) @(negedge clk_i);
    #2 resetn_i = 1'b0;
    #1;
    n_checks++;
    if ({byte_ready_o, bit_valid_o, bit_o, stuff_o, underrun_o} !== 5'b10000)
      $display("FAIL rstmid_async: got %b expected 10000", {byte_ready_o, bit_valid_o, bit_o, stuff_o, underrun_o});
    else n_pass++;
    @(negedge clk_i);
    resetn_i = 1'b1;
    repeat (20) begin
      @(negedge clk_i);
      if (bit_valid_o || !byte_ready_o || underrun_o) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL rstmid_quiet: got %0d active cycles expected 0", bad);
    else n_pass++;
  endtask

  task automatic test_random();
    int npk, nb;
    logic [7:0] d;
    for (int it = 0; it < 12; it++) begin
      tx_byte.delete();
      tx_last.delete();
      npk = $urandom_range(1, 3);
      for (int p = 0; p < npk; p++) begin
        nb = $urandom_range(1, 3);
        for (int b = 0; b < nb; b++) begin
          d = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom | $urandom);
          tx_byte.push_back(d);
          tx_last.push_back(b == nb - 1);
        end
      end
      if ($urandom_range(0, 3) == 0) tx_last[tx_last.size()-1] = 1'b0;
      model();
      run_stream(tx_byte.size() * 12 + 12);
      n_checks++;
      if (n_sent !== tx_byte.size() || nv !== exp_len || obs_bits !== exp_bits)
        $display("FAIL rand_bits[%0d]: got sent=%0d n=%0d %h expected sent=%0d n=%0d %h", it, n_sent, nv, obs_bits, tx_byte.size(), exp_len, exp_bits);
      else n_pass++;
      n_checks++;
      if (obs_stuff !== exp_stuff)
        $display("FAIL rand_stuff[%0d]: got %h expected %h", it, obs_stuff, exp_stuff);
      else n_pass++;
      n_checks++;
      if (gaps !== 0 || first_v !== first_acc + 2)
        $display("FAIL rand_timing[%0d]: got gaps=%0d first=%0d expected 0 %0d", it, gaps, first_v, first_acc + 2);
      else n_pass++;
      n_checks++;
      if (n_under !== exp_under || (exp_under == 1 && under_pos !== last_v + 1) || end_ready !== 1'b1 || end_valid !== 1'b0)
        $display("FAIL rand_end[%0d]: got under=%0d pos=%0d ready=%b valid=%b expected under=%0d pos=%0d 1 0", it, n_under, under_pos, end_ready, end_valid, exp_under, last_v + 1);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_all_ones();
    test_back_to_back();
    test_trailing_stuff();
    test_packet_boundary();
    test_underrun();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
